// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked multicycle ALU with iterative multiplier and optional divider
//
// Purpose:
//   Register-read to writeback ALU for the multicycle core. Single-cycle ops
//   (logic, add/sub, compares, shifts) complete with latency 1. MULTU is a
//   shift-add multiplier retiring one bit per cycle (WIDTH cycles in CALC).
//   Build option: define ALU_DIV_EN to add a restoring unsigned divider for
//   DIVU (ctrl 1011). Without it, 1011 behaves as an undefined code.
//
// Ports:
//   clk        in   1        rising-edge clock
//   reset      in   1        synchronous active-high reset
//   in_valid   in   1        operation request
//   in_ready   out  1        request can be accepted this cycle
//   ctrl       in   4        operation select
//   in1        in   WIDTH    operand A
//   in2        in   WIDTH    operand B
//   shamt      in   SHAMT_W  shift amount for SLL/SRL/SRA
//   out_valid  out  1        result/result_hi/zero are valid
//   out_ready  in   1        consumer takes the result this cycle
//   result     out  WIDTH    primary result (MULTU low word, DIVU quotient)
//   result_hi  out  WIDTH    MULTU high word, DIVU remainder, else 0
//   zero       out  1        registered (result == 0)
//   busy       out  1        iterative op in progress

module alu_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         ctrl,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   result_hi,
    output logic               zero,
    output logic               busy
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_MULT = 4'b1010;
`ifdef ALU_DIV_EN
    localparam logic [3:0] OP_DIVU = 4'b1011;
`endif

    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_hi_q;
    logic               zero_q;
    logic [WIDTH-1:0]   acc_q;      // MULTU partial high word / DIVU partial remainder
    logic [WIDTH-1:0]   lo_q;       // MULTU multiplier shifting out / DIVU dividend->quotient
    logic [WIDTH-1:0]   opb_q;      // captured multiplicand or divisor
    logic [SHAMT_W-1:0] cnt_q;
`ifdef ALU_DIV_EN
    logic               is_div_q;
`endif

    logic               accept;
    logic               is_iter;
    logic [WIDTH-1:0]   alu_res, alu_hi;
    logic [WIDTH-1:0]   acc_nx, lo_nx;
    logic [WIDTH:0]     mul_sum;
`ifdef ALU_DIV_EN
    logic [WIDTH:0]     div_shift, div_diff;
`endif

    assign accept = in_valid && in_ready;

    // Only ops that need CALC; a zero divisor is resolved immediately.
    always_comb begin
        is_iter = (ctrl == OP_MULT);
`ifdef ALU_DIV_EN
        if (ctrl == OP_DIVU && in2 != '0) begin
            is_iter = 1'b1;
        end
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = is_iter ? S_CALC : S_DONE;
                end
            end
            S_CALC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (accept) begin
                    state_d = is_iter ? S_CALC : S_DONE;
                end else if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic; in_ready is held low while reset is asserted.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_IDLE: in_ready = !reset;
            S_CALC: busy = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready && !reset;
            end
            default: ;
        endcase
    end

    // Single-cycle results, computed from the operands presented at accept.
    always_comb begin
        alu_res = '0;
        alu_hi  = '0;
        case (ctrl)
            OP_AND:  alu_res = in1 & in2;
            OP_OR:   alu_res = in1 | in2;
            OP_ADD:  alu_res = in1 + in2;
            OP_SUB:  alu_res = in1 - in2;
            OP_SLT:  alu_res[0] = ($signed(in1) < $signed(in2));
            OP_SLTU: alu_res[0] = (in1 < in2);
            OP_NOR:  alu_res = ~(in1 | in2);
            OP_SLL:  alu_res = in1 << shamt;
            OP_SRL:  alu_res = in1 >> shamt;
            OP_SRA:  alu_res = $signed(in1) >>> shamt;
`ifdef ALU_DIV_EN
            OP_DIVU: begin
                // Only reaches the result path when the divisor is zero.
                alu_res = '1;
                alu_hi  = in1;
            end
`endif
            default: ;
        endcase
    end

    // One iteration step of the multiplier or divider.
    always_comb begin
        // Shift-add: conditionally add multiplicand to the high word, then
        // shift the {carry, high, low} triple right by one.
        mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        acc_nx  = mul_sum[WIDTH:1];
        lo_nx   = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        // Restoring division: shift the next dividend bit into the remainder
        // and keep the subtraction only if it did not borrow.
        div_shift = {acc_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
                acc_nx = div_diff[WIDTH-1:0];
                lo_nx  = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_nx = div_shift[WIDTH-1:0];
                lo_nx  = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    // Datapath registers. Results only change on accept or on the final
    // CALC step, so DONE holds them stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            acc_q       <= '0;
            lo_q        <= '0;
            opb_q       <= '0;
            cnt_q       <= '0;
`ifdef ALU_DIV_EN
            is_div_q    <= 1'b0;
`endif
        end else if (accept) begin
            if (is_iter) begin
                acc_q    <= '0;
                lo_q     <= in1;
                opb_q    <= in2;
                cnt_q    <= '0;
`ifdef ALU_DIV_EN
                is_div_q <= (ctrl == OP_DIVU);
`endif
            end else begin
                result_q    <= alu_res;
                result_hi_q <= alu_hi;
                zero_q      <= (alu_res == '0);
            end
        end else if (state_q == S_CALC) begin
            acc_q <= acc_nx;
            lo_q  <= lo_nx;
            cnt_q <= cnt_q + SHAMT_W'(1);
            if (cnt_q == CNT_LAST) begin
                result_q    <= lo_nx;
                result_hi_q <= acc_nx;
                zero_q      <= (lo_nx == '0);
            end
        end
    end

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;

endmodule
